muldiv_unit: RTL and testbench

- Iterative RV32M execute unit: the consumer side of the decoded-operation interface for the M extension in the multicycle core.
- Control unit presents funct3 and two operands with valid; block returns a registered rd value with a one-cycle ready pulse.
- One shared datapath: a shift-add multiplier and a restoring divider. Signed operations are handled by magnitude conversion and final negation.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiplier and restoring divider sharing one
// accumulator, with sign handling by magnitude conversion and a final negation.
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int CYCLES = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            busy
);

    localparam int            CW   = $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_next;
    logic [2:0]          op;
    logic                sa, sb;
    logic [XLEN-1:0]     mb;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   acc;    // mul: {partial product, multiplier}; div: low half is dividend/quotient
    logic [XLEN:0]       rem;

    // Acceptance-side decode of signs, magnitudes and the div/rem corner cases.
    logic            sa_in, sb_in, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_val;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        special_val = '0;
        sa_in    = op_a[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                   funct3 == 3'b100 || funct3 == 3'b110);
        sb_in    = op_b[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
        mag_a    = sa_in ? -op_a : op_a;
        mag_b    = sb_in ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_val = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            special_val = funct3[1] ? '0 : op_a;
        end
    end

    // One multiply or divide step per CALC cycle, plus the sign-corrected final value.
    logic [XLEN:0]     mul_sum, div_shift, div_diff, rem_next;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quot, remd, final_val;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
        div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mb};
        div_ge    = div_shift >= {1'b0, mb};
        if (op[2]) begin
            acc_next = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};
            rem_next = div_ge ? div_diff : div_shift;
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
            rem_next = rem;
        end
        prod = (sa ^ sb) ? -acc_next : acc_next;
        quot = (sa ^ sb) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        remd = sa ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
        case (op)
            3'b000:                 final_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = quot;
            default:                final_val = remd;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = special ? DONE : CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            mb     <= '0;
            count  <= '0;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        op    <= funct3;
                        sa    <= sa_in;
                        sb    <= sb_in;
                        mb    <= mag_b;
                        count <= '0;
                        acc   <= {{XLEN{1'b0}}, mag_a};
                        rem   <= '0;
                        if (special) result <= special_val;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    rem   <= rem_next;
                    count <= count + 1'b1;
                    if (count == LAST) result <= final_val;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [31:0] result;
    logic        ready, busy;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32), .CYCLES(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result),
        .ready  (ready),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_muldiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              ai, bi;
        ai = a;
        bi = b;
        case (f3)
            3'd0: return 32'(a * b);
            3'd1: begin sp = longint'(ai) * longint'(bi); return sp[63:32]; end
            3'd2: begin sp = longint'(ai) * longint'({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ai / bi;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ai % bi;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one request; the next rising edge must find the DUT in IDLE. Returns the cycle
    // (acceptance cycle = 1) in which ready was seen, or 0 on timeout.
    task automatic exec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit keep_valid,
                        output logic [31:0] res, output int cyc);
        valid  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        cyc    = 0;
        res    = 'x;
        for (int c = 2; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                op_a   = $urandom;
                op_b   = $urandom;
                funct3 = 3'($urandom);
            end
            if (ready) begin
                cyc = c;
                res = result;
                break;
            end
        end
        if (!keep_valid) begin
            valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        valid  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        #1;
        checks++;
        if (result !== 32'h0 || ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h ready=%b busy=%b, want 0/0/0", result, ready, busy);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [2:0]  f3s [4] = '{3'd1, 3'd3, 3'd2, 3'd0};
        logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'h2, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] res;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            exec(f3s[i], as[i], bs[i], 1'b0, 1'b0, res, cyc);
            checks++;
            if (res !== exp[i] || cyc != 34) begin
                errors++;
                $display("FAIL mul_%0d: funct3=%0d result=%h cycle=%0d, want %h cycle 34", i, f3s[i], res, cyc, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s [3] = '{3'd4, 3'd6, 3'd5};
        logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
        logic [31:0] res;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            exec(f3s[i], 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, res, cyc);
            checks++;
            if (res !== exp[i] || cyc != 34) begin
                errors++;
                $display("FAIL div_%0d: funct3=%0d result=%h cycle=%0d, want %h cycle 34", i, f3s[i], res, cyc, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
        logic [31:0] res;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            exec(f3s[i], as[i], bs[i], 1'b0, 1'b0, res, cyc);
            checks++;
            if (res !== exp[i] || cyc != 2) begin
                errors++;
                $display("FAIL special_%0d: funct3=%0d result=%h cycle=%0d, want %h cycle 2", i, f3s[i], res, cyc, exp[i]);
            end
        end
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL special_after: ready=%b busy=%b result=%h, want 0/0 and result held 0", ready, busy, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s [3] = '{3'd4, 3'd6, 3'd3};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFE};
        int          lat [3] = '{2, 2, 34};
        logic [31:0] res;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            exec(f3s[i], as[i], 32'hFFFF_FFFF, 1'b0, i < 2, res, cyc);
            checks++;
            if (res !== exp[i] || cyc != lat[i]) begin
                errors++;
                $display("FAIL b2b_%0d: funct3=%0d result=%h cycle=%0d, want %h cycle %0d", i, f3s[i], res, cyc, exp[i], lat[i]);
            end
            if (i < 2) begin
                funct3 = f3s[i+1];
                op_a   = as[i+1];
                op_b   = 32'hFFFF_FFFF;
                @(posedge clk);
                #1;
                checks++;
                if (ready !== 1'b0 || busy !== 1'b0 || result !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_gap_%0d: ready=%b busy=%b result=%h, want 0/0/%h", i, ready, busy, result, exp[i]);
                end
            end
        end
    endtask

    task automatic test_operand_hold();
        logic [31:0] a, b, res, exp;
        logic [2:0]  f3;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            f3  = 3'(i);
            a   = $urandom;
            b   = $urandom | 32'h1;
            exp = ref_muldiv(f3, a, b);
            exec(f3, a, b, 1'b1, 1'b0, res, cyc);
            checks++;
            if (res !== exp || cyc != 34) begin
                errors++;
                $display("FAIL hold_%0d: a=%h b=%h result=%h cycle=%0d, want %h cycle 34", i, a, b, res, cyc, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic [2:0]  f3;
        int cyc, lat;
        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom);
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_muldiv(f3, a, b);
            lat = ref_latency(f3, a, b);
            exec(f3, a, b, 1'b0, 1'b0, res, cyc);
            checks++;
            if (res !== exp || cyc != lat) begin
                errors++;
                $display("FAIL random_%0d: funct3=%0d a=%h b=%h result=%h cycle=%0d, want %h cycle %0d",
                         i, f3, a, b, res, cyc, exp, lat);
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int cyc, stray;
        valid  = 1'b1;
        funct3 = 3'd5;
        op_a   = 32'hDEAD_BEEF;
        op_b   = 32'h0000_0123;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midcalc_busy: busy=%b, want 1", busy);
        end
        #2;
        resetn = 1'b0;
        valid  = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL midcalc_reset: ready=%b busy=%b result=%h, want 0/0/0", ready, busy, result);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        stray  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midcalc_abort: %0d cycles with ready/busy after abort, want 0", stray);
        end
        exec(3'd0, 32'd7, 32'd6, 1'b0, 1'b0, res, cyc);
        checks++;
        if (res !== 32'd42 || cyc != 34) begin
            errors++;
            $display("FAIL midcalc_mul: result=%0d cycle=%0d, want 42 cycle 34", res, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_operand_hold();
        test_random();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
